// File: rtl/start_pulse_gen.sv
// Button trigger front end: synchronizer, debouncer, rising-edge detect and an
// issue FSM that queues one request while downstream is busy and counts drops.
module start_pulse_gen #(
  parameter int unsigned DEB_CYCLES = 4,
  parameter int unsigned DC_W       = 3,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned WAIT_MAX   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn,
  input  logic             busy,
  output logic             start,
  output logic             pending,
  output logic             btn_level,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int unsigned WC_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FIRE = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RUN  = 2'd3;

  logic             s1_q, s2_q;
  logic             lvl_q, lvl_d;
  logic             lvl_dly_q;
  logic [DC_W-1:0]  dc_q, dc_d;
  logic [1:0]       state_q, state_d;
  logic [WC_W-1:0]  wc_q, wc_d;
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic             rise;
  logic             done;

  assign rise = lvl_q & ~lvl_dly_q;

  always_comb begin
    lvl_d = lvl_q;
    dc_d  = '0;
    if (s2_q != lvl_q) begin
      if (dc_q == DC_W'(DEB_CYCLES - 1)) begin
        lvl_d = s2_q;
      end else begin
        dc_d = dc_q + 1'b1;
      end
    end
  end

  // DONE handling is shared by WAIT timeout and RUN completion; a rise it
  // consumes never reaches the pending/drop path.
  always_comb begin
    state_d = state_q;
    wc_d    = wc_q;
    pend_d  = pend_q;
    drop_d  = drop_q;
    done    = 1'b0;
    case (state_q)
      S_IDLE: if (rise) state_d = S_FIRE;
      S_FIRE: begin
        wc_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (busy) begin
          state_d = S_RUN;
        end else if (wc_q == WC_W'(WAIT_MAX - 1)) begin
          done = 1'b1;
        end else begin
          wc_d = wc_q + 1'b1;
        end
      end
      default: if (!busy) done = 1'b1;
    endcase

    if (done) begin
      if (pend_q) begin
        state_d = S_FIRE;
        pend_d  = rise;
      end else if (rise) begin
        state_d = S_FIRE;
      end else begin
        state_d = S_IDLE;
      end
    end else if (rise && (state_q != S_IDLE)) begin
      if (!pend_q) begin
        pend_d = 1'b1;
      end else if (drop_q != '1) begin
        drop_d = drop_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      lvl_q     <= 1'b0;
      lvl_dly_q <= 1'b0;
      dc_q      <= '0;
      state_q   <= S_IDLE;
      wc_q      <= '0;
      pend_q    <= 1'b0;
      drop_q    <= '0;
    end else begin
      s1_q      <= btn;
      s2_q      <= s1_q;
      lvl_q     <= lvl_d;
      lvl_dly_q <= lvl_q;
      dc_q      <= dc_d;
      state_q   <= state_d;
      wc_q      <= wc_d;
      pend_q    <= pend_d;
      drop_q    <= drop_d;
    end
  end

  assign start     = (state_q == S_FIRE);
  assign pending   = pend_q;
  assign btn_level = lvl_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_start_pulse_gen.sv
// Directed bench for start_pulse_gen: latency, bounce rejection, queueing,
// WAIT timeout boundary, drop saturation and asynchronous reset.
module tb_start_pulse_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn;
  logic       busy;
  logic       start;
  logic       pending;
  logic       btn_level;
  logic [7:0] drop_cnt;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned nstart   = 0;

  start_pulse_gen #(
    .DEB_CYCLES(4),
    .DC_W      (3),
    .CNT_W     (8),
    .WAIT_MAX  (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn      (btn),
    .busy     (busy),
    .start    (start),
    .pending  (pending),
    .btn_level(btn_level),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Holds btn at v for n cycles, tallying any start pulses seen.
  task automatic hold(input logic v, input int unsigned n);
    btn = v;
    repeat (n) begin
      tick();
      if (start === 1'b1) nstart++;
    end
  endtask

  task automatic press();
    hold(1'b1, 8);
    hold(1'b0, 8);
  endtask

  logic bounce [5];

  initial begin
    rst  = 1'b1;
    btn  = 1'b0;
    busy = 1'b0;
    bounce = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    repeat (3) tick();
    chk("reset_outputs", 32'({start, pending, btn_level, drop_cnt}), 32'd0);
    rst = 1'b0;

    // 1: idle with button low
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("idle_quiet", 32'({start, pending, btn_level, drop_cnt}), 32'd0);
    end

    // 2: clean press, latency and busy window
    btn = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("clean_level", 32'(btn_level), 32'(k >= 6));
      chk("clean_start", 32'(start), 32'(k == 7));
    end
    busy = 1'b1;
    nstart = 0;
    repeat (12) begin
      tick();
      if (start === 1'b1) nstart++;
    end
    busy = 1'b0;
    hold(1'b0, 10);
    chk("clean_no_second_start", nstart, 32'd0);
    chk("clean_pending", 32'(pending), 32'd0);
    chk("release_level", 32'(btn_level), 32'd0);

    // 3: bounce 1,0,1,1,0 then stable high; stable from edge 6 -> start after edge 12
    for (int k = 1; k <= 20; k++) begin
      btn = (k <= 5) ? bounce[k-1] : 1'b1;
      tick();
      chk("bounce_level", 32'(btn_level), 32'(k >= 11));
      chk("bounce_start", 32'(start), 32'(k == 12));
    end
    hold(1'b0, 10);

    // 4: three presses in one busy window
    btn = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("q_first_start", 32'(start), 32'(k == 7));
    end
    busy = 1'b1;
    nstart = 0;
    hold(1'b0, 8);
    press();
    chk("q_pending_set", 32'(pending), 32'd1);
    chk("q_drop_zero", 32'(drop_cnt), 32'd0);
    press();
    chk("q_pending_kept", 32'(pending), 32'd1);
    chk("q_drop_one", 32'(drop_cnt), 32'd1);
    chk("q_no_start_busy", nstart, 32'd0);
    busy = 1'b0;
    tick();
    chk("q_second_start", 32'(start), 32'd1);
    chk("q_pending_clear", 32'(pending), 32'd0);
    nstart = 0;
    hold(1'b0, 10);
    chk("q_third_lost", nstart, 32'd0);

    // 4b: rise coincides with busy falling while pending is set
    nstart = 0;
    hold(1'b1, 8);
    chk("sim_first_start", nstart, 32'd1);
    busy = 1'b1;
    hold(1'b0, 8);
    press();
    chk("sim_pending", 32'(pending), 32'd1);
    hold(1'b1, 6);
    busy = 1'b0;
    tick();
    chk("sim_fire", 32'(start), 32'd1);
    chk("sim_pending_stays", 32'(pending), 32'd1);
    chk("sim_no_drop", 32'(drop_cnt), 32'd1);
    busy = 1'b1;
    nstart = 0;
    hold(1'b1, 2);
    hold(1'b0, 8);
    chk("sim_wait_busy", nstart, 32'd0);
    busy = 1'b0;
    tick();
    chk("sim_queued_fire", 32'(start), 32'd1);
    chk("sim_pending_done", 32'(pending), 32'd0);
    nstart = 0;
    hold(1'b0, 10);
    chk("sim_settle", nstart, 32'd0);

    // 5a: busy arrives one cycle after the WAIT window -> ignored in IDLE
    btn = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      tick();
      chk("to_start", 32'(start), 32'(k == 7));
    end
    busy = 1'b1;
    nstart = 0;
    hold(1'b0, 8);
    chk("to_pending_unchanged", 32'(pending), 32'd0);
    press();
    chk("to_idle_fires", nstart, 32'd1);
    chk("to_idle_no_pending", 32'(pending), 32'd0);
    busy = 1'b0;
    hold(1'b0, 4);

    // 5b: busy on the last WAIT cycle -> RUN, next press queues
    btn = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("lw_start", 32'(start), 32'(k == 7));
    end
    busy = 1'b1;
    nstart = 0;
    hold(1'b0, 8);
    press();
    chk("lw_no_start", nstart, 32'd0);
    chk("lw_pending", 32'(pending), 32'd1);

    // 5c: drive the drop counter to saturation
    for (int i = 2; i <= 256; i++) begin
      press();
      chk("sat_drop", 32'(drop_cnt), (i > 255) ? 32'd255 : 32'(i));
    end
    chk("sat_pending", 32'(pending), 32'd1);

    // 6: async reset mid-RUN with pending set
    btn = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("arst_outputs", 32'({start, pending, btn_level, drop_cnt}), 32'd0);
    tick();
    busy = 1'b0;
    rst  = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("arst_level", 32'(btn_level), 32'(k >= 6));
      chk("arst_start", 32'(start), 32'(k == 7));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
